key_entry_seq: RTL and testbench

KEY_ENTRY_SEQ -- requirements
Module: key_entry_seq

---
 rtl/key_entry_seq.sv | 144 ++++++++++++++
 tb/tb_key_entry_seq.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/key_entry_seq.sv
// Keypad digit entry buffer with display refresh sequencer.
// Collects up to NDIG BCD digits from a keypad, supports backspace and clear,
// and after every buffer-affecting key (and after reset) streams all digit
// positions to a display, rightmost first, one per cycle.

module key_entry_seq #(
  parameter int NDIG = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  key_valid,
  input  logic [3:0]            key_code,
  output logic                  key_ready,
  output logic                  wr_valid,
  output logic [3:0]            wr_pos,
  output logic [3:0]            wr_dig,
  output logic [3:0]            count,
  output logic [4*NDIG-1:0]     value,
  output logic                  overflow
);

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] REFRESH = 1'b1;

  localparam logic [3:0] LAST_POS   = 4'(NDIG - 1);
  localparam logic [3:0] FULL_COUNT = 4'(NDIG);

  localparam logic [3:0] CODE_MAX_DIGIT = 4'd9;
  localparam logic [3:0] CODE_BACKSPACE = 4'd10;
  localparam logic [3:0] CODE_CLEAR     = 4'd11;

  logic [0:0]          state_q, state_d;
  logic [4*NDIG-1:0]   value_q, value_d;
  logic [3:0]          count_q, count_d;
  logic                overflow_q, overflow_d;
  logic                wr_valid_q, wr_valid_d;
  logic [3:0]          wr_pos_q, wr_pos_d;
  logic [3:0]          wr_dig_q, wr_dig_d;
  logic                key_ready_q, key_ready_d;

  logic                accept;
  logic                start_refresh;
  logic [2:0]          next_pos;

  // Next-state logic: key handling in IDLE, position stepping in REFRESH.
  // A REFRESH entered with wr_valid low is the post-reset refresh that has
  // not yet emitted its first write.
  always_comb begin
    state_d       = state_q;
    value_d       = value_q;
    count_d       = count_q;
    overflow_d    = 1'b0;
    wr_valid_d    = 1'b0;
    wr_pos_d      = 4'd0;
    wr_dig_d      = 4'd0;
    start_refresh = 1'b0;
    next_pos      = wr_pos_q[2:0] + 3'd1;
    accept        = key_valid && key_ready_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (key_code <= CODE_MAX_DIGIT) begin
            if (count_q != FULL_COUNT) begin
              value_d = {value_q[4*NDIG-5:0], key_code};
              count_d = count_q + 4'd1;
            end else begin
              overflow_d = 1'b1;
            end
            start_refresh = 1'b1;
          end else if (key_code == CODE_BACKSPACE) begin
            if (count_q != 4'd0) begin
              value_d = {4'h0, value_q[4*NDIG-1:4]};
              count_d = count_q - 4'd1;
            end
            start_refresh = 1'b1;
          end else if (key_code == CODE_CLEAR) begin
            value_d       = '0;
            count_d       = 4'd0;
            start_refresh = 1'b1;
          end
        end
      end

      REFRESH: begin
        if (!wr_valid_q) begin
          start_refresh = 1'b1;
        end else if (wr_pos_q == LAST_POS) begin
          state_d = IDLE;
        end else begin
          wr_valid_d = 1'b1;
          wr_pos_d   = {1'b0, next_pos};
          wr_dig_d   = value_q[{next_pos, 2'b00} +: 4];
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (start_refresh) begin
      state_d    = REFRESH;
      wr_valid_d = 1'b1;
      wr_pos_d   = 4'd0;
      wr_dig_d   = value_d[3:0];
    end

    key_ready_d = (state_d == IDLE);
  end

  // Register all state and outputs; reset parks the sequencer at the start
  // of a refresh with no write pending.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= REFRESH;
      value_q     <= '0;
      count_q     <= 4'd0;
      overflow_q  <= 1'b0;
      wr_valid_q  <= 1'b0;
      wr_pos_q    <= 4'd0;
      wr_dig_q    <= 4'd0;
      key_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      value_q     <= value_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      wr_valid_q  <= wr_valid_d;
      wr_pos_q    <= wr_pos_d;
      wr_dig_q    <= wr_dig_d;
      key_ready_q <= key_ready_d;
    end
  end

  assign key_ready = key_ready_q;
  assign wr_valid  = wr_valid_q;
  assign wr_pos    = wr_pos_q;
  assign wr_dig    = wr_dig_q;
  assign count     = count_q;
  assign value     = value_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_key_entry_seq.sv
// Directed bench for key_entry_seq: a table of keys with hand-computed
// buffer contents, plus hand-written reset and held-valid sequences.

module tb_key_entry_seq;

  logic        clock;
  logic        reset;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_ready;
  logic        wr_valid;
  logic [3:0]  wr_pos;
  logic [3:0]  wr_dig;
  logic [3:0]  count;
  logic [31:0] value;
  logic        overflow;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    logic [3:0]  code;
    logic [31:0] exp_value;
    logic [3:0]  exp_count;
    logic        exp_ovf;
    logic        exp_refresh;
  } vec_t;

  localparam int NVEC = 19;
  vec_t vecs [NVEC];

  key_entry_seq #(.NDIG(8)) dut (
    .clock     (clock),
    .reset     (reset),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_ready (key_ready),
    .wr_valid  (wr_valid),
    .wr_pos    (wr_pos),
    .wr_dig    (wr_dig),
    .count     (count),
    .value     (value),
    .overflow  (overflow)
  );

  // Free-running clock, period 10.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Hard stop in case a sequence stalls beyond every local bound.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h required %0h", name, actual, expected);
    end
  endtask

  // Wait (bounded) at negedges until key_ready is high.
  task automatic wait_ready();
    int n = 0;
    while (key_ready !== 1'b1 && n < 50) begin
      @(negedge clock);
      n++;
    end
    check("ready_wait", {31'd0, key_ready}, 32'd1);
  endtask

  // Present one key for a single accepting edge; returns at the negedge
  // of the cycle after the accept edge.
  task automatic apply_stimulus(input logic [3:0] code);
    wait_ready();
    key_valid = 1'b1;
    key_code  = code;
    @(posedge clock);
    #1 key_valid = 1'b0;
    @(negedge clock);
  endtask

  // Called in the first cycle after the triggering edge: checks all eight
  // writes and the return to IDLE.
  task automatic check_refresh(input logic [31:0] exp_value, input logic exp_ovf);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clock);
      check("ref_valid", {31'd0, wr_valid}, 32'd1);
      check("ref_pos", {28'd0, wr_pos}, i);
      check("ref_dig", {28'd0, wr_dig}, {28'd0, exp_value[4*i +: 4]});
      check("ref_ready", {31'd0, key_ready}, 32'd0);
      check("ref_ovf", {31'd0, overflow}, (i == 0) ? {31'd0, exp_ovf} : 32'd0);
      check("ref_value", value, exp_value);
    end
    @(negedge clock);
    check("end_valid", {31'd0, wr_valid}, 32'd0);
    check("end_ready", {31'd0, key_ready}, 32'd1);
    check("end_ovf", {31'd0, overflow}, 32'd0);
  endtask

  task automatic check_output(input vec_t v);
    check("vec_value", value, v.exp_value);
    check("vec_count", {28'd0, count}, {28'd0, v.exp_count});
    if (v.exp_refresh) begin
      check_refresh(v.exp_value, v.exp_ovf);
    end else begin
      check("noref_valid", {31'd0, wr_valid}, 32'd0);
      check("noref_ready", {31'd0, key_ready}, 32'd1);
      check("noref_ovf", {31'd0, overflow}, 32'd0);
      @(negedge clock);
      check("noref_valid2", {31'd0, wr_valid}, 32'd0);
      check("noref_value2", value, v.exp_value);
    end
  endtask

  initial begin
    vecs[0]  = '{4'd1,  32'h00000001, 4'd1, 1'b0, 1'b1};
    vecs[1]  = '{4'd2,  32'h00000012, 4'd2, 1'b0, 1'b1};
    vecs[2]  = '{4'd3,  32'h00000123, 4'd3, 1'b0, 1'b1};
    vecs[3]  = '{4'd10, 32'h00000012, 4'd2, 1'b0, 1'b1};
    vecs[4]  = '{4'd11, 32'h00000000, 4'd0, 1'b0, 1'b1};
    vecs[5]  = '{4'd10, 32'h00000000, 4'd0, 1'b0, 1'b1};
    vecs[6]  = '{4'd13, 32'h00000000, 4'd0, 1'b0, 1'b0};
    vecs[7]  = '{4'd1,  32'h00000001, 4'd1, 1'b0, 1'b1};
    vecs[8]  = '{4'd2,  32'h00000012, 4'd2, 1'b0, 1'b1};
    vecs[9]  = '{4'd3,  32'h00000123, 4'd3, 1'b0, 1'b1};
    vecs[10] = '{4'd4,  32'h00001234, 4'd4, 1'b0, 1'b1};
    vecs[11] = '{4'd5,  32'h00012345, 4'd5, 1'b0, 1'b1};
    vecs[12] = '{4'd6,  32'h00123456, 4'd6, 1'b0, 1'b1};
    vecs[13] = '{4'd7,  32'h01234567, 4'd7, 1'b0, 1'b1};
    vecs[14] = '{4'd8,  32'h12345678, 4'd8, 1'b0, 1'b1};
    vecs[15] = '{4'd9,  32'h12345678, 4'd8, 1'b1, 1'b1};
    vecs[16] = '{4'd10, 32'h01234567, 4'd7, 1'b0, 1'b1};
    vecs[17] = '{4'd0,  32'h12345670, 4'd8, 1'b0, 1'b1};
    vecs[18] = '{4'd11, 32'h00000000, 4'd0, 1'b0, 1'b1};

    reset     = 1'b1;
    key_valid = 1'b0;
    key_code  = 4'd0;

    // Reset values, then the post-reset zero refresh.
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_value", value, 32'd0);
    check("rst_count", {28'd0, count}, 32'd0);
    check("rst_ovf", {31'd0, overflow}, 32'd0);
    check("rst_valid", {31'd0, wr_valid}, 32'd0);
    check("rst_pos", {28'd0, wr_pos}, 32'd0);
    check("rst_dig", {28'd0, wr_dig}, 32'd0);
    check("rst_ready", {31'd0, key_ready}, 32'd0);
    reset = 1'b0;
    @(negedge clock);
    check_refresh(32'd0, 1'b0);

    // Table-driven keys.
    for (int k = 0; k < NVEC; k++) begin
      apply_stimulus(vecs[k].code);
      check_output(vecs[k]);
    end

    // key_valid held high through a refresh: only one acceptance until
    // key_ready returns, then a second acceptance on the next edge.
    wait_ready();
    key_valid = 1'b1;
    key_code  = 4'd5;
    @(posedge clock);
    @(negedge clock);
    check("hold_value0", value, 32'h5);
    check("hold_pos0", {28'd0, wr_pos}, 32'd0);
    for (int i = 1; i < 8; i++) begin
      @(negedge clock);
      check("hold_ready", {31'd0, key_ready}, 32'd0);
      check("hold_value", value, 32'h5);
      check("hold_count", {28'd0, count}, 32'd1);
      check("hold_pos", {28'd0, wr_pos}, i);
    end
    @(negedge clock);
    check("hold_ready_back", {31'd0, key_ready}, 32'd1);
    check("hold_value_idle", value, 32'h5);
    @(posedge clock);
    #1 key_valid = 1'b0;
    @(negedge clock);
    check("hold_count2", {28'd0, count}, 32'd2);
    check_refresh(32'h55, 1'b0);

    // Reset in the middle of a refresh at the pos-3 write.
    apply_stimulus(4'd1);
    check("mid_value", value, 32'h551);
    repeat (3) @(negedge clock);
    check("mid_pos3", {28'd0, wr_pos}, 32'd3);
    check("mid_valid3", {31'd0, wr_valid}, 32'd1);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check("mid_rst_valid", {31'd0, wr_valid}, 32'd0);
    check("mid_rst_pos", {28'd0, wr_pos}, 32'd0);
    check("mid_rst_value", value, 32'd0);
    check("mid_rst_count", {28'd0, count}, 32'd0);
    check("mid_rst_ready", {31'd0, key_ready}, 32'd0);
    reset = 1'b0;
    @(negedge clock);
    check_refresh(32'd0, 1'b0);

    // Reset wins over a key presented on the same edge.
    apply_stimulus(4'd4);
    check_refresh(32'h4, 1'b0);
    reset     = 1'b1;
    key_valid = 1'b1;
    key_code  = 4'd7;
    @(posedge clock);
    #1 key_valid = 1'b0;
    @(negedge clock);
    check("prio_value", value, 32'd0);
    check("prio_count", {28'd0, count}, 32'd0);
    check("prio_valid", {31'd0, wr_valid}, 32'd0);
    reset = 1'b0;
    @(negedge clock);
    check_refresh(32'd0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
